// File: rtl/mem_access_if.sv
// EX-to-MEM request bundle and MEM-to-WB writeback packet.
// The master side is the EX stage (or bench); the slave side is the MEM stage.
interface mem_access_if #(
  parameter int ADDR_W = 8
);
  logic              ex_valid;
  logic [31:0]       ex_addr;
  logic [31:0]       ex_store_data;
  logic              ex_load_instr;
  logic              ex_store_instr;
  logic              ex_byte;
  logic [3:0]        ex_rd;
  logic              ex_rf_enable;
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [7:0]        init_data;
  logic              stall;
  logic              wb_valid;
  logic [31:0]       wb_data;
  logic [3:0]        wb_rd;
  logic              wb_rf_enable;

  modport master (
    output ex_valid, ex_addr, ex_store_data, ex_load_instr, ex_store_instr,
           ex_byte, ex_rd, ex_rf_enable, init_we, init_addr, init_data,
    input  stall, wb_valid, wb_data, wb_rd, wb_rf_enable
  );

  modport slave (
    input  ex_valid, ex_addr, ex_store_data, ex_load_instr, ex_store_instr,
           ex_byte, ex_rd, ex_rf_enable, init_we, init_addr, init_data,
    output stall, wb_valid, wb_data, wb_rd, wb_rf_enable
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: byte-wide big-endian data RAM, one byte per cycle,
// with a one-cycle writeback pulse towards WB.
module mem_access_stage #(
  parameter int ADDR_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  mem_access_if.slave  bus
);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]        state;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] base;
  logic [31:0]       st_data;
  logic [31:0]       hold;
  logic              is_load;
  logic              is_byte;
  logic [3:0]        rd;
  logic              rf_en;

  logic [7:0]        ram [2**ADDR_W];

  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        rd_byte;
  logic [7:0]        st_byte;
  logic              last;
  logic              mem_op;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;

  assign cur_addr  = base + ADDR_W'(cnt);
  assign rd_byte   = ram[cur_addr];
  assign last      = is_byte ? (cnt == 2'd0) : (cnt == 2'd3);
  assign mem_op    = bus.ex_load_instr | bus.ex_store_instr;
  assign bus.stall = (state != ST_IDLE);

  // Word stores go out most significant byte first.
  always_comb begin
    st_byte = st_data[7:0];
    if (!is_byte) begin
      case (cnt)
        2'd0:    st_byte = st_data[31:24];
        2'd1:    st_byte = st_data[23:16];
        2'd2:    st_byte = st_data[15:8];
        default: st_byte = st_data[7:0];
      endcase
    end
  end

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = cur_addr;
    ram_wdata = st_byte;
    if (!reset) begin
      if (state == ST_ACCESS && !is_load) begin
        ram_we = 1'b1;
      end else if (state == ST_IDLE && !bus.ex_valid && bus.init_we) begin
        ram_we    = 1'b1;
        ram_waddr = bus.init_addr;
        ram_wdata = bus.init_data;
      end
    end
  end

  // NOTE: the RAM has no reset so it maps onto memory primitives; contents
  // survive a pipeline reset by design.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      cnt              <= 2'd0;
      bus.wb_valid     <= 1'b0;
      bus.wb_data      <= 32'd0;
      bus.wb_rd        <= 4'd0;
      bus.wb_rf_enable <= 1'b0;
    end else begin
      bus.wb_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.ex_valid && !mem_op) begin
            bus.wb_valid     <= 1'b1;
            bus.wb_data      <= bus.ex_addr;
            bus.wb_rd        <= bus.ex_rd;
            bus.wb_rf_enable <= bus.ex_rf_enable;
          end else if (bus.ex_valid) begin
            // Word accesses are forced onto a 4-byte boundary, so they never wrap.
            base    <= bus.ex_byte ? bus.ex_addr[ADDR_W-1:0]
                                   : {bus.ex_addr[ADDR_W-1:2], 2'b00};
            st_data <= bus.ex_store_data;
            is_load <= bus.ex_load_instr;
            is_byte <= bus.ex_byte;
            rd      <= bus.ex_rd;
            rf_en   <= bus.ex_rf_enable;
            hold    <= 32'd0;
            cnt     <= 2'd0;
            state   <= ST_ACCESS;
          end
        end
        default: begin
          if (is_load) hold <= {hold[23:0], rd_byte};
          if (last) begin
            state            <= ST_IDLE;
            cnt              <= 2'd0;
            bus.wb_valid     <= 1'b1;
            bus.wb_rd        <= rd;
            bus.wb_rf_enable <= is_load & rf_en;
            if (is_load) bus.wb_data <= {hold[23:0], rd_byte};
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
      endcase
    end
  end
endmodule
